// File: rtl/sdram_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sdram_pkg : shared SDRAM command codes, read-engine states, helpers |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
package sdram_pkg;

  // {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] CMD_NOP        = 4'b0111;
  localparam logic [3:0] CMD_ACTIVE     = 4'b0011;
  localparam logic [3:0] CMD_READ       = 4'b0101;
  localparam logic [3:0] CMD_WRITE      = 4'b0100;
  localparam logic [3:0] CMD_BURST_STOP = 4'b0110;
  localparam logic [3:0] CMD_PRECHARGE  = 4'b0010;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ACT  = 3'd1,
    S_TRCD = 3'd2,
    S_RD   = 3'd3,
    S_DATA = 3'd4,
    S_PRE  = 3'd5,
    S_TRP  = 3'd6,
    S_END  = 3'd7
  } rd_state_e;

  // Extracts a width-bit field starting at lsb from a zero-extended address.
  function automatic logic [63:0] addr_field(input logic [63:0] addr,
                                             input int lsb, input int width);
    logic [63:0] mask;
    mask = (64'd1 << width) - 64'd1;
    return (addr >> lsb) & mask;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sdram_rd_capture.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sdram_rd_capture : CAS-latency delay line and DQ capture register   |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module sdram_rd_capture #(
  parameter int DATA_W  = 16,
  parameter int CAS_LAT = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_win,
  input  logic [DATA_W-1:0] dq_in,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_ack
);

  logic [CAS_LAT-1:0] win_q, win_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic               ack_q, ack_d;

  // win_q[CAS_LAT-1] marks the cycle in which DQ carries a requested word.
  always_comb begin
    win_d  = {win_q[CAS_LAT-2:0], rd_win};
    ack_d  = win_q[CAS_LAT-1];
    data_d = win_q[CAS_LAT-1] ? dq_in : data_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_q  <= '0;
      data_q <= '0;
      ack_q  <= 1'b0;
    end else begin
      win_q  <= win_d;
      data_q <= data_d;
      ack_q  <= ack_d;
    end
  end

  assign rd_data = data_q;
  assign rd_ack  = ack_q;

endmodule
`default_nettype wire

// File: rtl/sdram_burst_read.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sdram_burst_read : page-burst read engine (ACT/READ/BST/PRE)        |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module sdram_burst_read
  import sdram_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int BANK_W   = 2,
  parameter int ROW_W    = 13,
  parameter int COL_W    = 9,
  parameter int LEN_W    = 10,
  parameter int CAS_LAT  = 3,
  parameter int TRCD_CYC = 2,
  parameter int TRP_CYC  = 2
) (
  input  logic                          sys_clk,
  input  logic                          sys_rst,
  input  logic                          init_end,
  input  logic                          rd_en,
  input  logic [BANK_W+ROW_W+COL_W-1:0] rd_addr,
  input  logic [LEN_W-1:0]              rd_len,
  output logic                          rd_busy,
  output logic [3:0]                    rd_cmd,
  output logic [BANK_W-1:0]             rd_ba,
  output logic [ROW_W-1:0]              rd_sdram_addr,
  input  logic [DATA_W-1:0]             sdram_dq_in,
  output logic [DATA_W-1:0]             rd_data,
  output logic                          rd_ack,
  output logic                          rd_end
);

  // Counter must hold a full page length plus the CAS tail.
  localparam int CNT_W = ((LEN_W > COL_W) ? LEN_W : COL_W) + 3;
  localparam logic [CNT_W-1:0] PAGE_LEN = CNT_W'(1) << COL_W;
  localparam logic [ROW_W-1:0] A10_MASK = ROW_W'(1) << 10;

  rd_state_e          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   len_q, len_d;
  logic [BANK_W-1:0]  bank_q, bank_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic               busy_q, busy_d;
  logic [CNT_W-1:0]   len_req;
  logic               rd_win;

  assign len_req = CNT_W'(rd_len);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    bank_d  = bank_q;
    row_d   = row_q;
    col_d   = col_q;
    busy_d  = busy_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (init_end && rd_en) begin
          busy_d  = 1'b1;
          bank_d  = BANK_W'(addr_field(64'(rd_addr), ROW_W + COL_W, BANK_W));
          row_d   = ROW_W'(addr_field(64'(rd_addr), COL_W, ROW_W));
          col_d   = COL_W'(addr_field(64'(rd_addr), 0, COL_W));
          len_d   = (len_req > PAGE_LEN) ? PAGE_LEN : len_req;
          state_d = (rd_len == '0) ? S_END : S_ACT;
        end
      end
      S_ACT: begin
        cnt_d   = '0;
        state_d = (TRCD_CYC > 1) ? S_TRCD : S_RD;
      end
      S_TRCD: begin
        if (cnt_q == CNT_W'(TRCD_CYC - 2)) begin
          cnt_d   = '0;
          state_d = S_RD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RD: begin
        cnt_d   = '0;
        state_d = S_DATA;
      end
      S_DATA: begin
        // Stay until the last word has been sampled off DQ.
        if (cnt_q == len_q + CNT_W'(CAS_LAT - 2)) begin
          cnt_d   = '0;
          state_d = S_PRE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_PRE: begin
        cnt_d   = '0;
        state_d = S_TRP;
      end
      S_TRP: begin
        if (cnt_q == CNT_W'(TRP_CYC - 1)) begin
          cnt_d   = '0;
          state_d = S_END;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_END: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      bank_q  <= '0;
      row_q   <= '0;
      col_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      bank_q  <= bank_d;
      row_q   <= row_d;
      col_q   <= col_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    rd_cmd        = CMD_NOP;
    rd_ba         = '0;
    rd_sdram_addr = '1;
    case (state_q)
      S_ACT: begin
        rd_cmd        = CMD_ACTIVE;
        rd_ba         = bank_q;
        rd_sdram_addr = row_q;
      end
      S_RD: begin
        rd_cmd        = CMD_READ;
        rd_ba         = bank_q;
        rd_sdram_addr = ROW_W'(col_q) & ~A10_MASK;
      end
      S_DATA: begin
        if (cnt_q == len_q - CNT_W'(1)) begin
          rd_cmd = CMD_BURST_STOP;
        end
      end
      S_PRE: begin
        rd_cmd        = CMD_PRECHARGE;
        rd_ba         = bank_q;
        rd_sdram_addr = A10_MASK;
      end
      default: ;
    endcase
  end

  // READ-window: one strobe per requested word, starting at the READ cycle.
  assign rd_win  = (state_q == S_RD) ||
                   ((state_q == S_DATA) && ((cnt_q + CNT_W'(1)) < len_q));
  assign rd_busy = busy_q;
  assign rd_end  = (state_q == S_END);

  sdram_rd_capture #(
    .DATA_W (DATA_W),
    .CAS_LAT(CAS_LAT)
  ) u_capture (
    .clk    (sys_clk),
    .rst_n  (sys_rst),
    .rd_win (rd_win),
    .dq_in  (sdram_dq_in),
    .rd_data(rd_data),
    .rd_ack (rd_ack)
  );

endmodule
`default_nettype wire

// File: tb/tb_sdram_burst_read.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_sdram_burst_read : two geometries of the read engine vs. a      |
// | timing-formula reference and a reactive SDRAM DQ model  rev 1.0   |
// +--------------------------------------------------------------------+
module tb_sdram_burst_read;

  localparam int PAGE = 512;
  localparam logic [3:0] NOP = 4'b0111, ACT = 4'b0011, RD = 4'b0101,
                         BST = 4'b0110, PRE = 4'b0010;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        init_end;
  logic        rd_en;
  logic [23:0] rd_addr;
  logic [9:0]  rd_len;
  logic [3:0]  cmd   [2];
  logic [1:0]  ba    [2];
  logic [12:0] sa    [2];
  logic [15:0] dq    [2];
  logic [15:0] rdata [2];
  logic        ack   [2];
  logic        rend  [2];
  logic        busy  [2];

  int cas_p  [2] = '{3, 2};
  int trcd_p [2] = '{2, 1};
  int trp_p  [2] = '{2, 1};

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  sdram_burst_read u_dut0 (
    .sys_clk(clk), .sys_rst(rst_n), .init_end(init_end), .rd_en(rd_en),
    .rd_addr(rd_addr), .rd_len(rd_len), .rd_busy(busy[0]), .rd_cmd(cmd[0]),
    .rd_ba(ba[0]), .rd_sdram_addr(sa[0]), .sdram_dq_in(dq[0]),
    .rd_data(rdata[0]), .rd_ack(ack[0]), .rd_end(rend[0])
  );

  sdram_burst_read #(.CAS_LAT(2), .TRCD_CYC(1), .TRP_CYC(1)) u_dut1 (
    .sys_clk(clk), .sys_rst(rst_n), .init_end(init_end), .rd_en(rd_en),
    .rd_addr(rd_addr), .rd_len(rd_len), .rd_busy(busy[1]), .rd_cmd(cmd[1]),
    .rd_ba(ba[1]), .rd_sdram_addr(sa[1]), .sdram_dq_in(dq[1]),
    .rd_data(rdata[1]), .rd_ack(ack[1]), .rd_end(rend[1])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] dval(input int col, input logic [15:0] salt);
    return 16'(col % PAGE) ^ salt;
  endfunction

  task automatic check_reset_outputs(input string where);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("%s u%0d cmd", where, i), cmd[i], NOP);
      check($sformatf("%s u%0d ba", where, i), ba[i], 0);
      check($sformatf("%s u%0d addr", where, i), sa[i], 13'h1FFF);
      check($sformatf("%s u%0d data", where, i), rdata[i], 0);
      check($sformatf("%s u%0d ack", where, i), ack[i], 0);
      check($sformatf("%s u%0d end", where, i), rend[i], 0);
      check($sformatf("%s u%0d busy", where, i), busy[i], 0);
    end
  endtask

  // rd_en asserted while init_end is low must be ignored.
  task automatic init_gate();
    @(negedge clk);
    init_end = 1'b0;
    rd_en    = 1'b1;
    rd_addr  = 24'($urandom);
    rd_len   = 10'd5;
    repeat (4) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        check($sformatf("gate u%0d busy", i), busy[i], 0);
        check($sformatf("gate u%0d cmd", i), cmd[i], NOP);
      end
    end
    rd_en    = 1'b0;
    init_end = 1'b1;
  endtask

  // One request; every cycle of both engines is checked against event times
  // derived from the request. rst_ack>0 pulls reset at that rd_ack of unit 0.
  task automatic run_txn(input logic [1:0] b, input logic [12:0] r, input logic [8:0] c,
                         input logic [9:0] n, input logic [15:0] salt, input int rst_ack);
    int L, kmax;
    int t0[2], pre[2], endc[2], acks[2], rt[2], rcol[2], st[2];
    logic [3:0] ec;
    logic       ea;
    L    = (int'(n) > PAGE) ? PAGE : int'(n);
    kmax = 0;
    for (int i = 0; i < 2; i++) begin
      t0[i]   = 1 + trcd_p[i];
      pre[i]  = t0[i] + cas_p[i] + L;
      endc[i] = (L == 0) ? 1 : pre[i] + trp_p[i] + 1;
      acks[i] = 0;
      rt[i]   = -1;
      st[i]   = -1;
      rcol[i] = 0;
      if (endc[i] + 3 > kmax) kmax = endc[i] + 3;
    end
    @(negedge clk);
    rd_en   = 1'b1;
    rd_addr = {b, r, c};
    rd_len  = n;
    for (int k = 1; k <= kmax; k++) begin
      @(negedge clk);
      if (k == 1) begin
        rd_en   = 1'b0;
        rd_addr = 24'($urandom);
        rd_len  = 10'($urandom);
      end
      init_end = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 2; i++) begin
        ec = NOP;
        if (L > 0) begin
          if (k == 1)               ec = ACT;
          else if (k == t0[i])      ec = RD;
          else if (k == t0[i] + L)  ec = BST;
          else if (k == pre[i])     ec = PRE;
        end
        check($sformatf("u%0d k%0d cmd", i, k), cmd[i], ec);
        if (ec == ACT) begin
          check($sformatf("u%0d act ba", i), ba[i], b);
          check($sformatf("u%0d act row", i), sa[i], r);
        end
        if (ec == RD) begin
          check($sformatf("u%0d rd ba", i), ba[i], b);
          check($sformatf("u%0d rd col", i), sa[i], {4'b0, c});
        end
        if (ec == PRE) check($sformatf("u%0d pre a10", i), sa[i][10], 1);
        ea = (L > 0) && (k >= t0[i] + cas_p[i] + 1) && (k <= t0[i] + cas_p[i] + L);
        check($sformatf("u%0d k%0d ack", i, k), ack[i], ea);
        if (ea)
          check($sformatf("u%0d k%0d data", i, k), rdata[i],
                dval(int'(c) + k - t0[i] - cas_p[i] - 1, salt));
        check($sformatf("u%0d k%0d end", i, k), rend[i], k == endc[i]);
        check($sformatf("u%0d k%0d busy", i, k), busy[i], k <= endc[i]);
        if (ack[i]) acks[i]++;
        // SDRAM model: drives data after CAS latency from observed READ/BST.
        if (cmd[i] == RD) begin
          rt[i]   = k;
          rcol[i] = int'(sa[i][8:0]);
        end
        if (cmd[i] == BST) st[i] = k;
        if (rt[i] >= 0 && k >= rt[i] + cas_p[i] && (st[i] < 0 || k < st[i] + cas_p[i]))
          dq[i] = dval(rcol[i] + k - rt[i] - cas_p[i], salt);
        else
          dq[i] = 16'($urandom);
      end
      if (rst_ack > 0 && acks[0] == rst_ack) begin
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(negedge clk);
        check_reset_outputs("midrst_hold");
        rst_n    = 1'b1;
        init_end = 1'b1;
        return;
      end
    end
    init_end = 1'b1;
    for (int i = 0; i < 2; i++)
      check($sformatf("u%0d ack count", i), acks[i], L);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] len;
    rst_n    = 1'b0;
    init_end = 1'b0;
    rd_en    = 1'b0;
    rd_addr  = '0;
    rd_len   = '0;
    dq[0]    = '0;
    dq[1]    = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    init_gate();

    run_txn(2'd1, 13'h0123, 9'h010, 10'd8, 16'h0000, 0);
    run_txn(2'd3, 13'h1ABC, 9'h0A5, 10'd1, 16'h0000, 0);
    run_txn(2'd2, 13'h0042, 9'h077, 10'd0, 16'h0000, 0);
    run_txn(2'd0, 13'h0FFF, 9'h1FC, 10'd8, 16'h0000, 0);
    run_txn(2'd1, 13'h0777, 9'h003, 10'd1023, 16'h5A00, 0);
    run_txn(2'd2, 13'h0055, 9'h020, 10'd16, 16'hA5A5, 3);
    run_txn(2'd3, 13'h1234, 9'h100, 10'd6, 16'h0F0F, 0);

    for (int t = 0; t < 8; t++) begin
      if ($urandom_range(0, 3) == 0) len = 10'($urandom_range(0, 1023));
      else                           len = 10'($urandom_range(0, 20));
      run_txn(2'($urandom), 13'($urandom), 9'($urandom), len, 16'($urandom), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
